fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the hazard detection unit. It holds the PC and the IF/ID pipeline register and consumes holdPC and holdIF_ID from the hazard detection unit. It also consumes the branch redirect resolved in ID and feeds IF_ID_Instr to the hazard detection unit and the decoder. It inserts bubbles on flush and on instruction-memory wait, and keeps sticky misalignment and stall/flush statistics.

---
 rtl/mips_pkg.sv | 16 +
 rtl/if_id_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: instruction width, NOP encoding, reset PC and
// the opcodes the ID stage uses to resolve control flow.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [5:0]  OP_BEQ           = 6'h04;
  localparam logic [5:0]  OP_J             = 6'h02;

  // Instruction fetches are word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Hold freezes all fields; otherwise a bubble loads a
// NOP marked invalid, and a normal cycle captures the fetched instruction.
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_hold,
  input  logic               i_bubble,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc4,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc4,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_pc4;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_instr <= r_instr;
      r_pc4   <= r_pc4;
      r_valid <= r_valid;
    end else if (i_bubble) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect handling, IF/ID register and
// sticky misalignment / saturating stall and flush statistics.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               holdPC,
  input  logic               holdIF_ID,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic [31:0]        IF_ID_PC4,
  output logic               IF_ID_Valid,
  output logic               pc_misalign,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_pc;
  logic             r_pc_misalign;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic        w_redirect_ok;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_bubble;

  // imem_ready is a per-cycle valid: imem_rdata is only consumed in a cycle
  // where imem_ready=1, and the PC advances only on that same cycle.
  // A branch seen under any hold was compared with stale operands and is dropped.
  assign w_redirect_ok = branch_taken & ~holdPC & ~holdIF_ID;
  assign w_target      = word_align(branch_target);
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_bubble      = w_redirect_ok | holdPC | ~imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (holdPC) begin
      r_pc <= r_pc;
    end else if (w_redirect_ok) begin
      r_pc <= w_target;
    end else if (imem_ready) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_misalign <= 1'b0;
    end else if (w_redirect_ok && (branch_target[1:0] != 2'b00)) begin
      r_pc_misalign <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (holdPC && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
      if (w_redirect_ok && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .i_hold   (holdIF_ID),
    .i_bubble (w_bubble),
    .i_instr  (imem_rdata),
    .i_pc4    (w_pc_plus4),
    .o_instr  (IF_ID_Instr),
    .o_pc4    (IF_ID_PC4),
    .o_valid  (IF_ID_Valid)
  );

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_misalign = r_pc_misalign;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reference model predicts each cycle's registered
// state into a queue, popped and compared one cycle later.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          CW     = 4;
  localparam int          EXP_W  = 32 + 32 + 32 + 1 + 1 + CW + CW;

  logic          clk;
  logic          reset;
  logic          holdPC;
  logic          holdIF_ID;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_ready;
  logic [31:0]   pc;
  logic [31:0]   IF_ID_Instr;
  logic [31:0]   IF_ID_PC4;
  logic          IF_ID_Valid;
  logic          pc_misalign;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  logic [EXP_W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  // model state
  logic [31:0]   m_pc;
  logic [31:0]   m_instr;
  logic [31:0]   m_pc4;
  logic          m_valid;
  logic          m_mis;
  logic [CW-1:0] m_st;
  logic [CW-1:0] m_fl;

  fetch_stage #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .holdPC        (holdPC),
    .holdIF_ID     (holdIF_ID),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PC4     (IF_ID_PC4),
    .IF_ID_Valid   (IF_ID_Valid),
    .pc_misalign   (pc_misalign),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic hp, input logic hi,
                            input logic bt, input logic [31:0] tgt, input logic rdy);
    logic        ok;
    logic [31:0] npc;
    if (rst) begin
      m_pc = RST_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_mis = 1'b0; m_st = '0; m_fl = '0;
    end else begin
      ok = bt && !hp && !hi;
      if (hp)       npc = m_pc;
      else if (ok)  npc = {tgt[31:2], 2'b00};
      else if (rdy) npc = m_pc + 32'd4;
      else          npc = m_pc;
      if (!hi) begin
        if (ok || hp || !rdy) begin
          m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
          m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end
      end
      if (ok && tgt[1:0] != 2'b00) m_mis = 1'b1;
      if (hp && m_st != '1) m_st = m_st + 1'b1;
      if (ok && m_fl != '1) m_fl = m_fl + 1'b1;
      m_pc = npc;
    end
  endtask

  // driver: one clock cycle with the given inputs, then scoreboard compare
  task automatic step(input logic rst, input logic hp, input logic hi,
                      input logic bt, input logic [31:0] tgt, input logic rdy);
    logic [EXP_W-1:0] e;
    @(negedge clk);
    reset = rst; holdPC = hp; holdIF_ID = hi;
    branch_taken = bt; branch_target = tgt; imem_ready = rdy;
    model_step(rst, hp, hi, bt, tgt, rdy);
    exp_q.push_back({m_pc, m_instr, m_pc4, m_valid, m_mis, m_st, m_fl});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("pc",        pc,                   e[EXP_W-1 -: 32]);
    check_eq("imem_addr", imem_addr,            e[EXP_W-1 -: 32]);
    check_eq("instr",     IF_ID_Instr,          e[EXP_W-33 -: 32]);
    check_eq("pc4",       IF_ID_PC4,            e[EXP_W-65 -: 32]);
    check_eq("valid",     32'(IF_ID_Valid),     32'(e[2*CW+1]));
    check_eq("misalign",  32'(pc_misalign),     32'(e[2*CW]));
    check_eq("stall_cnt", 32'(stall_count),     32'(e[2*CW-1 -: CW]));
    check_eq("flush_cnt", 32'(flush_count),     32'(e[CW-1:0]));
  endtask

  task automatic run(input logic hp, input logic hi, input logic bt,
                     input logic [31:0] tgt, input logic rdy);
    step(1'b0, hp, hi, bt, tgt, rdy);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; holdPC = 1'b0; holdIF_ID = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; imem_ready = 1'b1;

    // reset and sequential fetch
    step(1'b1, 0, 0, 0, 32'h0, 1);
    step(1'b1, 0, 0, 0, 32'h0, 1);
    check_eq("rst_pc", pc, 32'h100);
    check_eq("rst_valid", 32'(IF_ID_Valid), 32'h0);
    run(0, 0, 0, 32'h0, 1);
    check_eq("seq_pc1", pc, 32'h104);
    check_eq("seq_valid", 32'(IF_ID_Valid), 32'h1);
    check_eq("seq_pc4", IF_ID_PC4, 32'h104);
    run(0, 0, 0, 32'h0, 1);
    check_eq("seq_pc2", pc, 32'h108);

    // load-use stall at 0x10
    run(0, 0, 1, 32'h10, 1);
    run(1, 1, 0, 32'h0, 1);
    check_eq("stall_pc", pc, 32'h10);
    check_eq("stall_cnt1", 32'(stall_count), 32'h1);
    run(0, 0, 0, 32'h0, 1);
    check_eq("stall_next", pc, 32'h14);

    // taken branch at 0x20 to 0x200
    run(0, 0, 1, 32'h20, 1);
    run(0, 0, 1, 32'h200, 1);
    check_eq("br_pc", pc, 32'h200);
    check_eq("br_bubble", 32'(IF_ID_Valid), 32'h0);
    run(0, 0, 0, 32'h0, 1);
    check_eq("br_instr", IF_ID_Instr, mem_word(32'h200));
    check_eq("br_pc4", IF_ID_PC4, 32'h204);
    check_eq("br_flush", 32'(flush_count), 32'h3);

    // branch under hold ignored, then accepted
    run(1, 1, 1, 32'h300, 1);
    check_eq("hold_br_pc", pc, 32'h204);
    check_eq("hold_br_flush", 32'(flush_count), 32'h3);
    run(0, 0, 1, 32'h300, 1);
    check_eq("rebr_pc", pc, 32'h300);

    // instruction memory wait at 0x40, redirects during wait
    run(0, 0, 1, 32'h40, 1);
    for (int i = 0; i < 3; i++) begin
      run(0, 0, 0, 32'h0, 0);
      check_eq("wait_pc", pc, 32'h40);
      check_eq("wait_bubble", 32'(IF_ID_Valid), 32'h0);
    end
    run(0, 0, 1, 32'h80, 0);
    check_eq("wait_redirect", pc, 32'h80);
    run(0, 0, 1, 32'h83, 1);
    check_eq("mis_pc", pc, 32'h80);
    check_eq("mis_flag", 32'(pc_misalign), 32'h1);
    run(0, 0, 0, 32'h0, 1);
    run(0, 0, 0, 32'h0, 1);
    check_eq("mis_sticky", 32'(pc_misalign), 32'h1);

    // stall counter saturation
    for (int i = 0; i < 20; i++) run(1, 0, 0, 32'h0, 1);
    check_eq("stall_sat", 32'(stall_count), 32'hF);

    // PC wrap
    run(0, 0, 1, 32'hFFFF_FFFC, 1);
    run(0, 0, 0, 32'h0, 1);
    check_eq("pc_wrap", pc, 32'h0);
    check_eq("wrap_pc4", IF_ID_PC4, 32'h0);

    // reset clears sticky flag and counters
    step(1'b1, 1, 0, 1, 32'h1, 1);
    check_eq("rst_mis", 32'(pc_misalign), 32'h0);
    check_eq("rst_stall", 32'(stall_count), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom_range(0, 32'h3FF);
      if (($urandom_range(0, 9)) == 0) tgt = 32'hFFFF_FFF0 | tgt[3:0];
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           tgt, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
